// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  typedef enum logic [4:0] {
    StIdle   = 5'b00001,
    StStart  = 5'b00010,
    StData   = 5'b00100,
    StParity = 5'b01000,
    StStop   = 5'b10000
  } tx_state_e;

  // Cycles per bit; integer division, remainder dropped.
  function automatic int unsigned baud_width(input int unsigned clock_speed,
                                             input int unsigned baud_rate);
    return clock_speed / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side word handshake into the UART transmitter FIFO.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Pushes into a full FIFO and pops from an empty one are dropped here.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5..9 data bits, optional parity, 1/2 stop bits)
// fed by an internal FIFO; frames stream back-to-back without idle bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned DATA_BITS   = 8,
  parameter parity_e     PARITY      = PAR_NONE,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_cfg_if.slave                  in_if,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BAUD_WIDTH = baud_width(CLOCK_SPEED, BAUD_RATE);
  localparam int unsigned CNT_W      = (BAUD_WIDTH < 2) ? 1 : $clog2(BAUD_WIDTH);
  localparam int unsigned IDX_W      = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_WIDTH - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  if (BAUD_WIDTH < 2) begin : g_bad_baud
    $error("uart_tx_cfg: CLOCK_SPEED / BAUD_RATE must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e            r_state;
  tx_state_e            w_state_next;
  logic [CNT_W-1:0]     r_baud;
  logic [CNT_W-1:0]     w_baud_next;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [IDX_W-1:0]     w_bit_next;
  logic                 r_stop_idx;
  logic                 w_stop_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 r_par;
  logic                 w_par_next;
  logic                 r_tx;
  logic                 w_tx_next;
  logic                 r_tx_done;
  logic                 w_done_next;
  logic                 w_bit_end;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_fifo_data;
  logic                 w_full;
  logic                 w_empty;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_if.data_valid),
    .i_data  (in_if.data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign in_if.data_ready = ~w_full;
  assign w_bit_end        = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud     <= w_baud_next;
      r_bit_idx  <= w_bit_next;
      r_stop_idx <= w_stop_next;
      r_shift    <= w_shift_next;
      r_par      <= w_par_next;
      r_tx       <= w_tx_next;
      r_tx_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = w_bit_end ? '0 : r_baud + CNT_W'(1);
    w_bit_next   = r_bit_idx;
    w_stop_next  = r_stop_idx;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    w_done_next  = 1'b0;
    w_tx_next    = 1'b1;

    unique case (r_state)
      StIdle: begin
        w_baud_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = StStart;
          w_bit_next   = '0;
          w_stop_next  = 1'b0;
        end
      end
      StStart: begin
        w_tx_next = 1'b0;
        if (w_bit_end) w_state_next = StData;
      end
      StData: begin
        w_tx_next = r_shift[0];
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == DATA_LAST) begin
            w_state_next = (PARITY == PAR_NONE) ? StStop : StParity;
          end else begin
            w_bit_next = r_bit_idx + IDX_W'(1);
          end
        end
      end
      StParity: begin
        w_tx_next = r_par;
        if (w_bit_end) w_state_next = StStop;
      end
      StStop: begin
        if (w_bit_end) begin
          if (r_stop_idx == STOP_LAST) begin
            w_done_next = 1'b1;
            // Chain straight into the next start bit when more data is queued.
            if (!w_empty) begin
              w_pop        = 1'b1;
              w_state_next = StStart;
              w_bit_next   = '0;
              w_stop_next  = 1'b0;
            end else begin
              w_state_next = StIdle;
            end
          end else begin
            w_stop_next = r_stop_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    if (w_pop) w_shift_next = w_fifo_data;
  end

  assign w_par_next = !w_pop ? r_par :
                      (PARITY == PAR_ODD) ? ~(^w_fifo_data) : (^w_fifo_data);

  // tx and tx_done are registered, so both trail the state register by one cycle.
  assign tx      = r_tx;
  assign tx_done = r_tx_done;
  assign busy    = (r_state != StIdle);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench: expected line patterns are queued at stimulus time and a
// monitor captures each frame on tx, comparing it when tx_done pulses.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   sel = 0;

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) if8  ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if7e ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if7o ();
  uart_tx_cfg_if #(.DATA_BITS(9)) if9  ();

  logic       tx8, busy8, done8;
  logic       tx7e, busy7e, done7e;
  logic       tx7o, busy7o, done7o;
  logic       tx9, busy9, done9;
  logic [2:0] cnt8, cnt7e, cnt7o, cnt9;

  uart_tx_cfg #(
    .CLOCK_SPEED (1_000_000), .BAUD_RATE (250_000), .DATA_BITS (8),
    .PARITY (uart_pkg::PAR_NONE), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) u_8n1 (
    .clk (clk), .rst (rst), .in_if (if8.slave), .tx (tx8), .busy (busy8),
    .tx_done (done8), .fifo_count (cnt8)
  );

  uart_tx_cfg #(
    .CLOCK_SPEED (1_000_000), .BAUD_RATE (250_000), .DATA_BITS (7),
    .PARITY (uart_pkg::PAR_EVEN), .STOP_BITS (2), .FIFO_DEPTH (4)
  ) u_7e2 (
    .clk (clk), .rst (rst), .in_if (if7e.slave), .tx (tx7e), .busy (busy7e),
    .tx_done (done7e), .fifo_count (cnt7e)
  );

  uart_tx_cfg #(
    .CLOCK_SPEED (1_000_000), .BAUD_RATE (250_000), .DATA_BITS (7),
    .PARITY (uart_pkg::PAR_ODD), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) u_7o1 (
    .clk (clk), .rst (rst), .in_if (if7o.slave), .tx (tx7o), .busy (busy7o),
    .tx_done (done7o), .fifo_count (cnt7o)
  );

  uart_tx_cfg #(
    .CLOCK_SPEED (1_000_000), .BAUD_RATE (250_000), .DATA_BITS (9),
    .PARITY (uart_pkg::PAR_ODD), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) u_9o1 (
    .clk (clk), .rst (rst), .in_if (if9.slave), .tx (tx9), .busy (busy9),
    .tx_done (done9), .fifo_count (cnt9)
  );

  // Observed DUT, selected per scenario.
  logic       m_tx, m_busy, m_done, m_ready;
  logic [2:0] m_cnt;

  always_comb begin
    m_tx = tx8; m_busy = busy8; m_done = done8; m_ready = if8.data_ready; m_cnt = cnt8;
    case (sel)
      1: begin m_tx = tx7e; m_busy = busy7e; m_done = done7e; m_ready = if7e.data_ready;
               m_cnt = cnt7e; end
      2: begin m_tx = tx7o; m_busy = busy7o; m_done = done7o; m_ready = if7o.data_ready;
               m_cnt = cnt7o; end
      3: begin m_tx = tx9; m_busy = busy9; m_done = done9; m_ready = if9.data_ready;
               m_cnt = cnt9; end
      default: ;
    endcase
  end

  int    total = 0;
  int    bad   = 0;
  string exp_q[$];
  int    done_times[$];
  int    cyc = 0;
  bit    in_frame = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: one sample per cycle, frame opens on the start bit, closes on tx_done.
  logic [63:0] samples;
  int          ncyc;
  int          busy_low;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && m_tx == 1'b0) begin
        in_frame = 1'b1;
        ncyc     = 0;
        busy_low = 0;
        samples  = '0;
      end
      if (in_frame) begin
        if (ncyc < 64) samples[ncyc] = m_tx;
        ncyc++;
        if (!m_busy && !m_done) busy_low++;
      end
      if (m_done) begin
        done_times.push_back(cyc);
        check("done_inside_frame", in_frame, 1'b1);
        check("sb_pending", exp_q.size() > 0, 1'b1);
        if (in_frame && exp_q.size() > 0) begin
          string       pat;
          logic [63:0] expv;
          pat  = exp_q.pop_front();
          expv = '0;
          for (int i = 0; i < pat.len() * 4 && i < 64; i++) expv[i] = (pat.getc(i / 4) == "1");
          check("frame_len", ncyc, pat.len() * 4);
          check("frame_line", samples, expv);
          check("busy_in_frame", busy_low, 0);
        end
        in_frame = 1'b0;
      end
    end
  end

  task automatic set_in(input int s, input logic v, input logic [8:0] w);
    case (s)
      0: begin if8.data  = w[7:0]; if8.data_valid  = v; end
      1: begin if7e.data = w[6:0]; if7e.data_valid = v; end
      2: begin if7o.data = w[6:0]; if7o.data_valid = v; end
      default: begin if9.data = w; if9.data_valid = v; end
    endcase
  endtask

  task automatic push_word(input int s, input logic [8:0] w);
    @(negedge clk);
    set_in(s, 1'b1, w);
    @(posedge clk);
    #1;
    set_in(s, 1'b0, 9'h000);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", n < budget, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          n0;
    int          n;
    logic [8:0]  burst[3];
    logic [8:0]  fill[6];

    for (int s = 0; s < 4; s++) set_in(s, 1'b0, 9'h000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_tx", m_tx, 1'b1);
    check("rst_busy", m_busy, 1'b0);
    check("rst_done", m_done, 1'b0);
    check("rst_ready", m_ready, 1'b1);
    check("rst_count", m_cnt, 3'd0);

    // 8N1 0xA5 with push/pop/tx latency.
    exp_q.push_back("0101001011");
    @(negedge clk);
    set_in(0, 1'b1, 9'h0A5);
    @(posedge clk); #1;
    set_in(0, 1'b0, 9'h000);
    check("cnt_after_push", m_cnt, 3'd1);
    check("busy_before_pop", m_busy, 1'b0);
    @(posedge clk); #1;
    check("cnt_after_pop", m_cnt, 3'd0);
    check("busy_at_start", m_busy, 1'b1);
    check("tx_before_fall", m_tx, 1'b1);
    @(posedge clk); #1;
    check("tx_fall", m_tx, 1'b0);
    wait_drain(100);

    // Parity variants.
    sel = 1;
    exp_q.push_back("01000001011");
    push_word(1, 9'h041);
    wait_drain(100);
    sel = 2;
    exp_q.push_back("0100000111");
    push_word(2, 9'h041);
    wait_drain(100);
    sel = 3;
    exp_q.push_back("011111111101");
    push_word(3, 9'h1FF);
    wait_drain(100);

    // Back-to-back burst.
    sel   = 0;
    burst = '{9'h000, 9'h0FF, 9'h055};
    exp_q.push_back("0000000001");
    exp_q.push_back("0111111111");
    exp_q.push_back("0101010101");
    n0 = done_times.size();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1'b1, burst[i]);
      @(posedge clk); #1;
    end
    set_in(0, 1'b0, 9'h000);
    wait_drain(300);
    check("burst_done_count", done_times.size() - n0, 3);
    if (done_times.size() >= n0 + 3) begin
      check("burst_gap1", done_times[n0 + 1] - done_times[n0], 40);
      check("burst_gap2", done_times[n0 + 2] - done_times[n0 + 1], 40);
    end

    // FIFO fill: six offered, five accepted.
    fill = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};
    exp_q.push_back("0100010001");
    exp_q.push_back("0010001001");
    exp_q.push_back("0110011001");
    exp_q.push_back("0001000101");
    exp_q.push_back("0101010101");
    n0 = done_times.size();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1'b1, fill[i]);
      @(posedge clk); #1;
      if (i == 0) check("fill_cnt1", m_cnt, 3'd1);
      if (i == 3) check("fill_ready_at3", m_ready, 1'b1);
      if (i == 4) begin
        check("fill_cnt_full", m_cnt, 3'd4);
        check("fill_ready_low", m_ready, 1'b0);
      end
    end
    set_in(0, 1'b0, 9'h000);
    check("fill_cnt_after_reject", m_cnt, 3'd4);
    wait_drain(400);
    check("fill_done_count", done_times.size() - n0, 5);

    // Mid-frame reset with one word still queued.
    n0 = done_times.size();
    @(negedge clk);
    set_in(0, 1'b1, 9'h0A5);
    @(posedge clk); #1;
    set_in(0, 1'b1, 9'h077);
    @(posedge clk); #1;
    set_in(0, 1'b0, 9'h000);
    n = 0;
    while (m_tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_frame_started", m_tx, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx", m_tx, 1'b1);
    check("midrst_busy", m_busy, 1'b0);
    check("midrst_ready", m_ready, 1'b1);
    check("midrst_count", m_cnt, 3'd0);
    check("midrst_done", m_done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("midrst_no_done", done_times.size() - n0, 0);
    repeat (2) @(negedge clk);
    exp_q.push_back("0001111001");
    push_word(0, 9'h03C);
    wait_drain(100);
    check("post_rst_done_count", done_times.size() - n0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
